// File: rtl/spike_rate_monitor_if.sv
// Bus between the neuron readout stage and the spike-rate monitor.
interface spike_rate_monitor_if #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 12
) ();
    logic             ena;
    logic             spike;
    logic [7:0]       state;
    logic [WIN_W-1:0] win_len;
    logic             clear;
    logic [CNT_W-1:0] rate;
    logic [ISI_W-1:0] isi_min;
    logic [7:0]       peak;
    logic             result_valid;
    logic             overflow;

    modport master (
        output ena, spike, state, win_len, clear,
        input  rate, isi_min, peak, result_valid, overflow
    );

    modport slave (
        input  ena, spike, state, win_len, clear,
        output rate, isi_min, peak, result_valid, overflow
    );
endinterface

// File: rtl/spike_rate_monitor.sv
// Windowed neuron activity monitor: spike count, minimum ISI and peak membrane state.
module spike_rate_monitor #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spike_rate_monitor_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t             fsm_q, fsm_nxt;
    logic             spike_d_q, spike_d_nxt;
    logic [WIN_W-1:0] win_len_q, win_len_nxt;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [7:0]       peak_run_q, peak_run_nxt;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_nxt;
    logic [ISI_W-1:0] isi_run_q, isi_run_nxt;
    logic             armed_q, armed_nxt;

    logic [CNT_W-1:0] rate_q, rate_nxt;
    logic [ISI_W-1:0] isi_min_q, isi_min_nxt;
    logic [7:0]       peak_q, peak_nxt;
    logic             result_valid_q, result_valid_nxt;
    logic             overflow_q, overflow_nxt;

    logic             spike_evt_c;
    logic             win_clr;
    logic [CNT_W-1:0] count_upd;
    logic [7:0]       peak_upd;
    logic [ISI_W-1:0] isi_cnt_upd;
    logic [ISI_W-1:0] isi_run_upd;
    logic             armed_upd;
    logic [ISI_W-1:0] isi_delta;

    assign spike_evt_c = bus.spike & ~spike_d_q;

    // Next-state, window datapath and result publication
    always_comb begin
        fsm_nxt          = fsm_q;
        spike_d_nxt      = spike_d_q;
        win_len_nxt      = win_len_q;
        win_cnt_nxt      = win_cnt_q;
        count_nxt        = count_q;
        peak_run_nxt     = peak_run_q;
        isi_cnt_nxt      = isi_cnt_q;
        isi_run_nxt      = isi_run_q;
        armed_nxt        = armed_q;
        rate_nxt         = rate_q;
        isi_min_nxt      = isi_min_q;
        peak_nxt         = peak_q;
        overflow_nxt     = overflow_q;
        result_valid_nxt = 1'b0;
        win_clr          = 1'b0;
        count_upd        = count_q;
        peak_upd         = peak_run_q;
        isi_cnt_upd      = isi_cnt_q;
        isi_run_upd      = isi_run_q;
        armed_upd        = armed_q;
        isi_delta        = '0;

        if (bus.ena) begin
            spike_d_nxt = bus.spike;
            if (bus.clear) begin
                fsm_nxt      = IDLE;
                overflow_nxt = 1'b0;
                win_clr      = 1'b1;
            end else begin
                case (fsm_q)
                    IDLE: begin
                        if (bus.win_len != '0) begin
                            win_len_nxt = bus.win_len;
                            fsm_nxt     = RUN;
                            win_clr     = 1'b1;
                        end
                    end
                    RUN: begin
                        if (spike_evt_c) begin
                            if (count_q == CNT_MAX) begin
                                overflow_nxt = 1'b1;
                            end else begin
                                count_upd = count_q + CNT_W'(1);
                            end
                            // delta = cycles between this event and the previous one
                            if (armed_q) begin
                                isi_delta = (isi_cnt_q == ISI_MAX) ? ISI_MAX
                                                                   : isi_cnt_q + ISI_W'(1);
                                if (isi_delta < isi_run_q) begin
                                    isi_run_upd = isi_delta;
                                end
                            end
                            armed_upd   = 1'b1;
                            isi_cnt_upd = '0;
                        end else if (armed_q && (isi_cnt_q != ISI_MAX)) begin
                            isi_cnt_upd = isi_cnt_q + ISI_W'(1);
                            if (isi_cnt_upd == ISI_MAX) begin
                                overflow_nxt = 1'b1;
                            end
                        end

                        peak_upd = (bus.state > peak_run_q) ? bus.state : peak_run_q;

                        if (win_cnt_q == (win_len_q - WIN_W'(1))) begin
                            rate_nxt         = count_upd;
                            isi_min_nxt      = isi_run_upd;
                            peak_nxt         = peak_upd;
                            result_valid_nxt = 1'b1;
                            win_len_nxt      = bus.win_len;
                            win_clr          = 1'b1;
                            if (bus.win_len == '0) begin
                                fsm_nxt = IDLE;
                            end
                        end else begin
                            win_cnt_nxt  = win_cnt_q + WIN_W'(1);
                            count_nxt    = count_upd;
                            peak_run_nxt = peak_upd;
                            isi_cnt_nxt  = isi_cnt_upd;
                            isi_run_nxt  = isi_run_upd;
                            armed_nxt    = armed_upd;
                        end
                    end
                    default: fsm_nxt = IDLE;
                endcase
            end

            // Fresh window: counters, peak and ISI tracking restart
            if (win_clr) begin
                win_cnt_nxt  = '0;
                count_nxt    = '0;
                peak_run_nxt = '0;
                isi_cnt_nxt  = '0;
                isi_run_nxt  = ISI_MAX;
                armed_nxt    = 1'b0;
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q          <= IDLE;
            spike_d_q      <= 1'b0;
            win_len_q      <= '0;
            win_cnt_q      <= '0;
            count_q        <= '0;
            peak_run_q     <= '0;
            isi_cnt_q      <= '0;
            isi_run_q      <= ISI_MAX;
            armed_q        <= 1'b0;
            rate_q         <= '0;
            isi_min_q      <= ISI_MAX;
            peak_q         <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            fsm_q          <= fsm_nxt;
            spike_d_q      <= spike_d_nxt;
            win_len_q      <= win_len_nxt;
            win_cnt_q      <= win_cnt_nxt;
            count_q        <= count_nxt;
            peak_run_q     <= peak_run_nxt;
            isi_cnt_q      <= isi_cnt_nxt;
            isi_run_q      <= isi_run_nxt;
            armed_q        <= armed_nxt;
            rate_q         <= rate_nxt;
            isi_min_q      <= isi_min_nxt;
            peak_q         <= peak_nxt;
            result_valid_q <= result_valid_nxt;
            overflow_q     <= overflow_nxt;
        end
    end

    assign bus.rate         = rate_q;
    assign bus.isi_min      = isi_min_q;
    assign bus.peak         = peak_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Self-checking bench for spike_rate_monitor with a window-level reference model.
module tb_spike_rate_monitor;

    localparam int unsigned WIN_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ISI_W = 12;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    spike_rate_monitor_if #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) bus ();

    spike_rate_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: per window, a list of event positions plus a running peak
    bit   m_run;
    int   m_len;
    int   m_pos;
    int   m_ev[$];
    int   m_peak;
    bit   m_prev;
    int   exp_rate;
    int   exp_isi;
    int   exp_peak;
    bit   exp_valid;
    bit   exp_ovf;

    task automatic model_reset();
        m_run = 0; m_len = 0; m_pos = 0; m_ev.delete(); m_peak = 0; m_prev = 0;
        exp_rate = 0; exp_isi = 4095; exp_peak = 0; exp_valid = 0; exp_ovf = 0;
    endtask

    task automatic model_step();
        bit ev;
        exp_valid = 0;
        if (!bus.ena) return;
        ev = bus.spike && !m_prev;
        m_prev = bus.spike;
        if (bus.clear) begin
            m_run = 0; exp_ovf = 0; m_ev.delete();
        end else if (!m_run) begin
            if (bus.win_len != 0) begin
                m_run = 1; m_len = int'(bus.win_len); m_pos = 0; m_ev.delete(); m_peak = 0;
            end
        end else begin
            if (ev) begin
                if (m_ev.size() >= 255) exp_ovf = 1;
                m_ev.push_back(m_pos);
            end else if (m_ev.size() > 0 && (m_pos - m_ev[$]) == 4095) begin
                exp_ovf = 1;
            end
            if (int'(bus.state) > m_peak) m_peak = int'(bus.state);
            if (m_pos == m_len - 1) begin
                exp_rate = (m_ev.size() > 255) ? 255 : m_ev.size();
                exp_isi  = 4095;
                for (int i = 1; i < m_ev.size(); i++) begin
                    int d;
                    d = m_ev[i] - m_ev[i-1];
                    if (d > 4095) d = 4095;
                    if (d < exp_isi) exp_isi = d;
                end
                exp_peak  = m_peak;
                exp_valid = 1;
                m_len = int'(bus.win_len); m_pos = 0; m_ev.delete(); m_peak = 0;
                if (m_len == 0) m_run = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: model consumes current inputs, outputs sampled 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Stop any running window without touching published results
    task automatic flush();
        bus.spike = 0; bus.win_len = 0; bus.clear = 1; bus.ena = 1;
        tick();
        bus.clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #12;
        n_checks++;
        if ({bus.rate, bus.isi_min, bus.peak, bus.result_valid, bus.overflow} !== {8'd0, 12'hFFF, 8'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values got rate=%0d isi=%h peak=%0d v=%b ovf=%b", bus.rate, bus.isi_min, bus.peak, bus.result_valid, bus.overflow);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.result_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle_no_strobe got %b need 0", bus.result_valid);
            end
        end
    endtask

    task automatic test_basic();
        bus.win_len = 10;
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.spike = (c == 2 || c == 5 || c == 9);
            bus.state = 8'($urandom);
            tick();
            if (c < 9) begin
                n_checks++;
                if (bus.result_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL basic_early_valid cycle %0d got %b need 0", c, bus.result_valid);
                end
            end
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate, bus.isi_min, bus.overflow} !== {1'b1, 8'd3, 12'd3, 1'b0}) begin
            n_errors++;
            $display("FAIL basic_result got v=%b rate=%0d isi=%0d ovf=%b need 1/3/3/0", bus.result_valid, bus.rate, bus.isi_min, bus.overflow);
        end
        n_checks++;
        if (int'(bus.peak) !== exp_peak) begin
            n_errors++;
            $display("FAIL basic_peak got %0d need %0d", bus.peak, exp_peak);
        end
        tick();
        n_checks++;
        if (bus.result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_single_pulse got %b need 0", bus.result_valid);
        end
        flush();
    endtask

    task automatic test_held();
        logic [7:0] ramp [8];
        ramp = '{8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd50, 8'd30, 8'd20};
        bus.win_len = 8;
        tick();
        for (int c = 0; c < 8; c++) begin
            bus.spike = (c >= 1 && c <= 6);
            bus.state = ramp[c];
            tick();
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate, bus.isi_min, bus.peak} !== {1'b1, 8'd1, 12'hFFF, 8'd80}) begin
            n_errors++;
            $display("FAIL held_result got v=%b rate=%0d isi=%h peak=%0d need 1/1/fff/80", bus.result_valid, bus.rate, bus.isi_min, bus.peak);
        end
        flush();
    endtask

    task automatic test_saturate();
        bus.state = 0;
        bus.win_len = 600;
        tick();
        for (int c = 0; c < 600; c++) begin
            bus.spike = (c % 2 == 1);
            tick();
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate, bus.isi_min, bus.overflow} !== {1'b1, 8'd255, 12'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL sat_result got v=%b rate=%0d isi=%0d ovf=%b need 1/255/2/1", bus.result_valid, bus.rate, bus.isi_min, bus.overflow);
        end
        flush();
        n_checks++;
        if ({bus.overflow, bus.rate, bus.isi_min, bus.result_valid} !== {1'b0, 8'd255, 12'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL sat_clear got ovf=%b rate=%0d isi=%0d v=%b need 0/255/2/0", bus.overflow, bus.rate, bus.isi_min, bus.result_valid);
        end
    endtask

    task automatic test_stall();
        bus.win_len = 20;
        tick();
        for (int c = 0; c < 20; c++) begin
            bus.spike = (c == 3 || c == 13);
            tick();
            if (c == 7) begin
                bus.ena = 0;
                bus.spike = 1;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    n_checks++;
                    if (bus.result_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL stall_strobe got %b need 0", bus.result_valid);
                    end
                end
                bus.ena = 1;
            end
            if (c < 19) begin
                n_checks++;
                if (bus.result_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_early_valid cycle %0d got %b need 0", c, bus.result_valid);
                end
            end
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate, bus.isi_min} !== {1'b1, 8'd2, 12'd10}) begin
            n_errors++;
            $display("FAIL stall_result got v=%b rate=%0d isi=%0d need 1/2/10", bus.result_valid, bus.rate, bus.isi_min);
        end
        flush();
    endtask

    task automatic test_reset_mid();
        bus.state = 8'd99;
        bus.win_len = 10;
        tick();
        for (int c = 0; c < 4; c++) begin
            bus.spike = (c == 1 || c == 3);
            tick();
        end
        bus.spike = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if ({bus.rate, bus.isi_min, bus.peak, bus.result_valid, bus.overflow} !== {8'd0, 12'hFFF, 8'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL rstmid_values got rate=%0d isi=%h peak=%0d v=%b ovf=%b", bus.rate, bus.isi_min, bus.peak, bus.result_valid, bus.overflow);
        end
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.spike = (c == 5);
            tick();
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate, bus.isi_min, bus.peak} !== {1'b1, 8'd1, 12'hFFF, 8'd99}) begin
            n_errors++;
            $display("FAIL rstmid_result got v=%b rate=%0d isi=%h peak=%0d need 1/1/fff/99", bus.result_valid, bus.rate, bus.isi_min, bus.peak);
        end
        flush();
    endtask

    task automatic test_win_len_change();
        bus.win_len = 10;
        tick();
        for (int c = 0; c < 10; c++) begin
            bus.spike = (c == 4);
            if (c == 4) bus.win_len = 0;
            tick();
        end
        bus.spike = 0;
        n_checks++;
        if ({bus.result_valid, bus.rate} !== {1'b1, 8'd1}) begin
            n_errors++;
            $display("FAIL wl_complete got v=%b rate=%0d need 1/1", bus.result_valid, bus.rate);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            n_checks++;
            if (bus.result_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL wl_idle_strobe cycle %0d got %b need 0", i, bus.result_valid);
            end
        end
        bus.win_len = 5;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++;
            if (bus.result_valid !== (k % 5 == 0)) begin
                n_errors++;
                $display("FAIL wl_period k=%0d got %b need %b", k, bus.result_valid, (k % 5 == 0));
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        bus.win_len = 1;
        tick();
        for (int k = 0; k < 8; k++) begin
            bus.spike = (k % 2 == 1);
            tick();
            n_checks++;
            if ({bus.result_valid, bus.rate, bus.isi_min} !== {1'b1, 8'(k % 2), 12'hFFF}) begin
                n_errors++;
                $display("FAIL b2b k=%0d got v=%b rate=%0d isi=%h need 1/%0d/fff", k, bus.result_valid, bus.rate, bus.isi_min, k % 2);
            end
        end
        flush();
    endtask

    task automatic test_random();
        logic [29:0] got;
        logic [29:0] want;
        bus.win_len = 7;
        for (int i = 0; i < 3000; i++) begin
            bus.ena   = ($urandom % 8) != 0;
            bus.spike = ($urandom % 3) == 0;
            bus.state = 8'($urandom);
            bus.clear = ($urandom % 200) == 0;
            if (($urandom % 100) == 0) bus.win_len = 16'($urandom_range(0, 12));
            tick();
            got  = {bus.rate, bus.isi_min, bus.peak, bus.result_valid, bus.overflow};
            want = {8'(exp_rate), 12'(exp_isi), 8'(exp_peak), exp_valid, exp_ovf};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL random cycle %0d got %h need %h", i, got, want);
            end
        end
        bus.ena = 1;
        bus.clear = 0;
        flush();
    endtask

    initial begin
        bus.ena = 1; bus.spike = 0; bus.state = 0; bus.win_len = 0; bus.clear = 0;
        test_reset();
        test_basic();
        test_held();
        test_saturate();
        test_stall();
        test_reset_mid();
        test_win_len_change();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
Downstream consumer of the neuron top-level outputs (8-bit membrane state, spike bit). Measures neuron activity over a programmable window: spike count, minimum inter-spike interval (ISI) and peak membrane state. Publishes the results once per window with a single-cycle valid strobe. Feeds the debug/readout mux and the characterisation bench.

Parameters:
WIN_W, 16, width of window-length input and window counter
CNT_W, 8, width of spike-count result (saturating)
ISI_W, 12, width of ISI counter and result (saturating)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low = all internal state holds, no strobes
spike  in  1  neuron spike level (uio_out[7] of the neuron top)
state  in  8  neuron membrane state (uo_out of the neuron top), unsigned
win_len  in  WIN_W  window length in ena-cycles; 0 = monitor idle
clear  in  1  synchronous restart: abort window, clear sticky flag
rate  out  CNT_W  spikes counted in last completed window
isi_min  out  ISI_W  minimum ISI in last window; all-ones if fewer than 2 spikes
peak  out  8  maximum state seen in last window
result_valid  out  1  one-cycle pulse when rate/isi_min/peak update
overflow  out  1  sticky; set when a count or ISI saturates

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except isi_min = all-ones; FSM to IDLE; spike_d=0; all counters 0.
- Everything below applies only in cycles with ena=1. With ena=0 all registers hold, result_valid=0, and spike_d is not updated.
- Edge detect: event = spike & ~spike_d. spike_d <= spike each ena cycle. A level held high for N cycles = 1 event.
- FSM IDLE: if win_len != 0, latch win_len_q <= win_len and go to RUN. Window counters, count, peak and ISI tracking are cleared on entry.
- FSM RUN: first RUN cycle is window cycle 0; win_cnt increments each cycle. win_len changes mid-window are ignored.
- count: +1 per event, saturates at 2^CNT_W-1. An event arriving while count is at max sets overflow.
- peak: running max of state over all window cycles, including cycle 0 and the last cycle.
- ISI:
  - isi_cnt = cycles since the previous event in this window; saturates at 2^ISI_W-1 and sets overflow on saturation.
  - The first event in a window arms tracking and sets isi_cnt=0.
  - Each later event compares the event-cycle delta to the running min, takes the min, then restarts isi_cnt.
  - Events in consecutive cycles are impossible (edge detect), so the minimum ISI is 2.
- Window end: the cycle with win_cnt == win_len_q-1. That cycle's event and state are included.
  - Next cycle: rate, isi_min and peak register the totals; result_valid=1 for exactly 1 cycle.
  - In that same cycle a new window starts at cycle 0 with win_len re-latched, or the FSM goes to IDLE if win_len == 0.
  - win_len_q=1 produces a result every cycle after the first.
- clear=1 (any state): FSM to IDLE, window state cleared, overflow cleared, no result_valid. Published rate/isi_min/peak keep their values. clear has priority over window end.
- Reset mid-window: immediate abort; no result published.
- No ISI spans a window boundary; tracking re-arms each window.

Test Plan:
- win_len=10, 1-cycle spike pulses at window cycles 2,5,9 -> result_valid pulses once at cycle 10; rate=3, isi_min=3, overflow=0.
- win_len=8, spike held high for cycles 1..6, state ramps 10..80 then back to 20 -> rate=1, isi_min=0xFFF, peak=80.
- win_len=600, spike toggles every cycle (event every 2 cycles, 300 events) -> rate=255, isi_min=2, overflow=1. A following clear pulse drops overflow to 0 and leaves rate=255.
- win_len=20, pulses at cycles 3 and 13; ena low for 5 cycles between them -> isi_min=10. result_valid arrives 5 cycles later than it would without the stall.
- rst_n asserted at window cycle 4 of a 10-cycle window after 2 spikes -> all outputs at reset values immediately. The first result_valid after release reflects only post-reset spikes.
- win_len switched 10→0 mid-window -> current window completes with a valid result, then IDLE with no further strobes. Setting win_len=5 restarts periodic strobes every 5 cycles.
